// File: rtl/input_debouncer.sv
// Purpose : synchronise one bouncy asynchronous input and accept a level change only
//           after DEBOUNCE_CYCLES consecutive synchronised samples agree; emit edge pulses.
// Latency : clean step first sampled at edge 1 moves clean_out at edge SYNC_STAGES+DEBOUNCE_CYCLES.
// Backpressure: none; free-running, consumes one raw sample per clock.
//
// Ports:
//   clk           single clock, all logic on posedge
//   reset_n       asynchronous active-low reset
//   raw_in        asynchronous raw input (pin/switch)
//   glitch_clr    synchronous clear of glitch_count (wins over a simultaneous glitch)
//   clean_out     debounced level (registered)
//   rise_pulse    one-cycle pulse on accepted 0->1 change
//   fall_pulse    one-cycle pulse on accepted 1->0 change
//   glitch_count  saturating count of rejected level changes
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                raw_in,
    input  logic                glitch_clr,
    output logic                clean_out,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GC_ONE   = GLITCH_W'(1);
    localparam logic [GLITCH_W-1:0] GC_MAX   = {GLITCH_W{1'b1}};

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [GLITCH_W-1:0]    glitch_q, glitch_d;
    logic                   glitch_evt;

    // Synchroniser chain: raw_in enters at bit 0, sync_in is the oldest stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= LOW;
            cnt_q    <= '0;
            clean_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clean_q  <= clean_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    // Entering a CHK state already counts the first sample at the new level,
    // so acceptance happens when the DEBOUNCE_CYCLES-th agreeing sample arrives.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clean_d    = clean_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        glitch_evt = 1'b0;
        case (state_q)
            LOW: begin
                clean_d = 1'b0;
                if (sync_in) begin
                    state_d = RISE_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            RISE_CHK: begin
                if (!sync_in) begin
                    state_d    = LOW;
                    cnt_d      = '0;
                    glitch_evt = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    clean_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                clean_d = 1'b1;
                if (!sync_in) begin
                    state_d = FALL_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            FALL_CHK: begin
                if (sync_in) begin
                    state_d    = HIGH;
                    cnt_d      = '0;
                    glitch_evt = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
                clean_d = 1'b0;
            end
        endcase
    end

    // Clear has priority; otherwise count rejected changes and stick at all-ones.
    always_comb begin
        glitch_d = glitch_q;
        if (glitch_clr) begin
            glitch_d = '0;
        end else if (glitch_evt && (glitch_q != GC_MAX)) begin
            glitch_d = glitch_q + GC_ONE;
        end
    end

    assign clean_out    = clean_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign glitch_count = glitch_q;

endmodule
